row_smoothing_filter: RTL and testbench

//  Parametrised successor to the fixed 8-bit smoothing filter: causal moving average over 2^WIN_LOG2 samples.

---
 rtl/smoothing_pkg.sv | 15 +
 rtl/sample_window_shreg.sv | 36 +++
 rtl/row_smoothing_filter.sv | 94 +++++++++
 tb/tb_row_smoothing_filter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smoothing_pkg.sv
// Shared constants and width helpers for the row smoothing filter.
package smoothing_pkg;

   localparam int EDGE_ZERO = 0;
   localparam int EDGE_REPL = 1;

   function automatic int sum_width(input int data_w, input int win_log2);
      return data_w + win_log2;
   endfunction

   function automatic int col_width(input int row_len);
      return $clog2(row_len);
   endfunction

endpackage

// File: rtl/sample_window_shreg.sv
// Purpose: DEPTH-deep sample delay line with shift, clear-and-load and fill; exposes the oldest tap.
// Latency: taps update on the clock edge after a command.
// Backpressure: none; commands are acted on in the cycle they are asserted.
module sample_window_shreg #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift,
   input  logic              clear,
   input  logic              fill,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] oldest
);

   logic [DATA_W-1:0] taps [DEPTH];

   // clear empties the line and loads din as the newest sample in the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else if (fill) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= din;
      end else if (clear) begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) taps[i] <= '0;
      end else if (shift) begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign oldest = taps[DEPTH-1];

endmodule

// File: rtl/row_smoothing_filter.sv
// Purpose: causal per-row moving average over 2^WIN_LOG2 samples with edge padding and rounding.
// Latency: 1 clk from accept to out_valid.
// Backpressure: none; enb=0 freezes state, every accepted sample produces one output.
module row_smoothing_filter
   import smoothing_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int WIN_LOG2  = 2,
   parameter int ROW_LEN   = 150,
   parameter int EDGE_MODE = EDGE_ZERO,
   parameter int ROUND     = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enb,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       row_restart,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_eol,
   output logic [col_width(ROW_LEN)-1:0] col_idx
);

   localparam int N     = 1 << WIN_LOG2;
   localparam int SUM_W = sum_width(DATA_W, WIN_LOG2);
   localparam int COL_W = col_width(ROW_LEN);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
   localparam logic [SUM_W-1:0] RND      = (ROUND != 0) ? SUM_W'(N / 2) : '0;

   logic              accept;
   logic              row_first;
   logic              at_last;
   logic [COL_W-1:0]  col_eff;
   logic [SUM_W-1:0]  sum_q;
   logic [SUM_W-1:0]  sum_d;
   logic [SUM_W-1:0]  sum_rnd;
   logic [DATA_W-1:0] oldest;

   assign accept    = enb & in_valid;
   assign col_eff   = row_restart ? '0 : col_idx;
   assign row_first = (col_eff == '0);
   assign at_last   = (col_eff == LAST_COL);

   // A row's first sample re-seeds the sum instead of subtracting a stale tap
   always_comb begin
      sum_d = sum_q;
      if (row_first) begin
         if (EDGE_MODE == EDGE_REPL) sum_d = SUM_W'(in_data) << WIN_LOG2;
         else                        sum_d = SUM_W'(in_data);
      end else begin
         sum_d = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
      end
   end

   assign sum_rnd = sum_d + RND;

   sample_window_shreg #(
      .DATA_W (DATA_W),
      .DEPTH  (N)
   ) u_window (
      .clk    (clk),
      .reset  (reset),
      .shift  (accept & ~row_first),
      .clear  (accept & row_first & (EDGE_MODE != EDGE_REPL)),
      .fill   (accept & row_first & (EDGE_MODE == EDGE_REPL)),
      .din    (in_data),
      .oldest (oldest)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eol   <= 1'b0;
         col_idx   <= '0;
         sum_q     <= '0;
      end else if (enb) begin
         out_valid <= in_valid;
         out_eol   <= in_valid & at_last;
         if (in_valid) begin
            sum_q    <= sum_d;
            out_data <= sum_rnd[SUM_W-1:WIN_LOG2];
            col_idx  <= at_last ? '0 : col_eff + COL_W'(1);
         end else if (row_restart) begin
            col_idx  <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_row_smoothing_filter.sv
// Bench for row_smoothing_filter: a zero-pad/rounding and a replicate/truncating instance share one stimulus.
module tb_row_smoothing_filter;

   localparam int DW  = 8;
   localparam int WL  = 2;
   localparam int RL  = 8;
   localparam int NW  = 1 << WL;

   logic          clk;
   logic          reset;
   logic          enb;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          row_restart;

   logic          ov_z, oe_z, ov_r, oe_r;
   logic [DW-1:0] od_z, od_r;
   logic [2:0]    oc_z, oc_r;

   row_smoothing_filter #(.DATA_W(DW), .WIN_LOG2(WL), .ROW_LEN(RL), .EDGE_MODE(0), .ROUND(1)) dut_z (
      .clk(clk), .reset(reset), .enb(enb), .in_valid(in_valid), .in_data(in_data),
      .row_restart(row_restart), .out_valid(ov_z), .out_data(od_z), .out_eol(oe_z), .col_idx(oc_z));

   row_smoothing_filter #(.DATA_W(DW), .WIN_LOG2(WL), .ROW_LEN(RL), .EDGE_MODE(1), .ROUND(0)) dut_r (
      .clk(clk), .reset(reset), .enb(enb), .in_valid(in_valid), .in_data(in_data),
      .row_restart(row_restart), .out_valid(ov_r), .out_data(od_r), .out_eol(oe_r), .col_idx(oc_r));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // reference model: samples of the current row, and the expected outputs
   int            row_q[$];
   logic          e_valid = 1'b0;
   logic          e_eol   = 1'b0;
   logic [2:0]    e_col   = '0;
   logic [DW-1:0] e_dz    = '0;
   logic [DW-1:0] e_dr    = '0;

   wire [25:0] obs  = {ov_z, oe_z, oc_z, od_z, ov_r, oe_r, oc_r, od_r};
   wire [25:0] expv = {e_valid, e_eol, e_col, e_dz, e_valid, e_eol, e_col, e_dr};

   // average of the last NW samples of the row, padding before column 0
   function automatic int model_avg(input int em, input int rnd);
      int s;
      int idx;
      s = 0;
      for (int k = 0; k < NW; k++) begin
         idx = row_q.size() - 1 - k;
         if (idx >= 0)     s += row_q[idx];
         else if (em == 1) s += row_q[0];
      end
      return (s + ((rnd != 0) ? NW / 2 : 0)) / NW;
   endfunction

   task automatic step(input bit rst, input bit en, input bit vld, input logic [DW-1:0] d, input bit rr);
      @(negedge clk);
      reset = rst; enb = en; in_valid = vld; in_data = d; row_restart = rr;
      if (rst) begin
         row_q.delete();
         e_valid = 1'b0; e_eol = 1'b0; e_dz = '0; e_dr = '0;
      end else if (!en) begin
         e_valid = 1'b0; e_eol = 1'b0;
      end else begin
         if (rr) row_q.delete();
         e_valid = vld;
         e_eol   = 1'b0;
         if (vld) begin
            row_q.push_back(int'(d));
            e_dz = DW'(model_avg(0, 1));
            e_dr = DW'(model_avg(1, 0));
            if (row_q.size() == RL) begin
               e_eol = 1'b1;
               row_q.delete();
            end
         end
      end
      e_col = 3'(row_q.size());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1);
      step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
      checks++;
      if (obs !== 26'b0) begin
         fails++;
         $display("FAIL reset_state: got %h want %h", obs, 26'b0);
      end
   endtask

   task automatic test_edge_replicate();
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < RL; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'd100, 1'b0);
         checks++;
         if (obs !== expv || od_r !== 8'd100 || oe_r !== (i == RL - 1)) begin
            fails++;
            $display("FAIL edge_repl[%0d]: got %h (data %0d eol %b) want %h", i, obs, od_r, oe_r, expv);
         end
      end
   endtask

   task automatic test_zero_pad();
      logic [DW-1:0] want [RL];
      want = '{8'd25, 8'd50, 8'd75, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
      for (int i = 0; i < RL; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'd100, 1'b0);
         checks++;
         if (obs !== expv || od_z !== want[i]) begin
            fails++;
            $display("FAIL zero_pad[%0d]: got %h (data %0d) want %h (data %0d)", i, obs, od_z, expv, want[i]);
         end
      end
   endtask

   task automatic test_rounding();
      logic [DW-1:0] want [8];
      want = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd64, 8'd128, 8'd191, 8'd255};
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1, (i < 4) ? 8'd1 : 8'd255, i == 4);
         checks++;
         if (obs !== expv || od_z !== want[i]) begin
            fails++;
            $display("FAIL rounding[%0d]: got %h (data %0d) want %h (data %0d)", i, obs, od_z, expv, want[i]);
         end
      end
   endtask

   task automatic test_ramp();
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b1, DW'(i), 1'b0);
         checks++;
         if (obs !== expv || (i == 8 && od_z !== 8'd2) || oe_z !== (i == 7 || i == 15)) begin
            fails++;
            $display("FAIL ramp[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_gaps();
      int gap;
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 2 * RL; i++) begin
         if (i == 5) begin
            for (int f = 0; f < 3; f++) begin
               step(1'b0, 1'b0, 1'b1, DW'($urandom_range(0, 255)), 1'b1);
               checks++;
               if (obs !== expv) begin
                  fails++;
                  $display("FAIL freeze[%0d]: got %h want %h", f, obs, expv);
               end
            end
         end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 255)), 1'b0);
            checks++;
            if (obs !== expv) begin
               fails++;
               $display("FAIL gap[%0d]: got %h want %h", i, obs, expv);
            end
         end
         step(1'b0, 1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0);
         checks++;
         if (obs !== expv) begin
            fails++;
            $display("FAIL gap_data[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_restart();
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'd200, 1'b1);
      checks++;
      if (obs !== expv || od_z !== 8'd50 || oc_z !== 3'd1 || oe_z !== 1'b0) begin
         fails++;
         $display("FAIL restart_accept: got %h want %h", obs, expv);
      end
      step(1'b0, 1'b1, 1'b1, 8'd40, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
      checks++;
      if (obs !== expv || oc_z !== 3'd0) begin
         fails++;
         $display("FAIL restart_idle: got %h want %h", obs, expv);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, DW'($urandom_range(0, 255)), 1'b0);
         checks++;
         if (obs !== expv) begin
            fails++;
            $display("FAIL restart_refill[%0d]: got %h want %h", i, obs, expv);
         end
      end
      step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
      checks++;
      if (obs !== 26'b0) begin
         fails++;
         $display("FAIL reset_midrow: got %h want %h", obs, 26'b0);
      end
   endtask

   task automatic test_random();
      bit rst, en, vld, rr;
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 9) != 0);
         vld = ($urandom_range(0, 9) < 7);
         rr  = ($urandom_range(0, 19) == 0);
         step(rst, en, vld, DW'($urandom_range(0, 255)), rr);
         checks++;
         if (obs !== expv) begin
            fails++;
            $display("FAIL random[%0d]: got %h want %h", i, obs, expv);
         end
      end
   endtask

   initial begin
      reset = 1'b1; enb = 1'b0; in_valid = 1'b0; in_data = '0; row_restart = 1'b0;
      test_reset();
      test_edge_replicate();
      test_zero_pad();
      test_rounding();
      test_ramp();
      test_gaps();
      test_restart();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
